fetch_unit: RTL and testbench

- Instruction fetch stage directly downstream of the program counter register.
- Samples the current instruction address and runs a req/ack transaction to instruction memory.
- Buffers each returned instruction with its address in a small FIFO for decode.
- Drives the PC write-enable, so the PC advances only when a fetch completes or a flush redirects it.

---
 rtl/fetch_pkg.sv | 30 +++
 rtl/fetch_fifo.sv | 99 +++++++++
 rtl/fetch_unit.sv | 173 +++++++++++++++++
 tb/tb_fetch_unit.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared types and defaults for the instruction fetch stage.
//   - ADDR_W_DEF / INSTR_W_DEF : default address and instruction widths
//   - fetch_state_e            : fetch FSM states (IDLE / REQ / DROP)
//   - fetch_entry_t            : fetch buffer entry {instr, pc} at default widths
//   - fetch_cnt_w()            : width of an occupancy counter for a given depth
// -----------------------------------------------------------------------------
package fetch_pkg;

  localparam int ADDR_W_DEF  = 16;
  localparam int INSTR_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [INSTR_W_DEF-1:0] instr;
    logic [ADDR_W_DEF-1:0]  pc;
  } fetch_entry_t;

  // The counter must represent 0..depth inclusive, hence one bit more than the pointer.
  function automatic int fetch_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Synchronous fetch buffer between the fetch FSM and decode.
// Ports:
//   clk_i        : clock, rising edge
//   rst_i        : synchronous active-high reset; clears pointers, count and
//                  every storage entry (so the head reads zero after reset)
//   clear_i      : flush; empties the buffer (pointers/count) without touching
//                  storage; overrides push/pop in the same cycle
//   push_i       : write push_data_i at the tail
//   pop_i        : drop the head entry
//   push_data_i  : entry to write
//   head_o       : entry at the read pointer (valid when count_o != 0)
//   count_o      : number of stored entries, 0..DEPTH
// Parameters:
//   DEPTH   : number of entries, power of two, >= 2
//   entry_t : stored entry type
// Callers guarantee no push when full and no pop when empty.
// -----------------------------------------------------------------------------
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter type entry_t = fetch_entry_t,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int CNT_W   = fetch_cnt_w(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  entry_t           push_data_i,
  output entry_t           head_o,
  output logic [CNT_W-1:0] count_o
);

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Pointer and occupancy next-state; DEPTH is a power of two so the
  // pointers wrap naturally on overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) begin
        wr_ptr_d = wr_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_i) begin
        rd_ptr_d = rd_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        2'b01:   count_d = count_q - {{(CNT_W-1){1'b0}}, 1'b1};
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer/count registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; a flush leaves stale data behind, only reset zeroes it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push_i && !clear_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage sitting right after the PC register. Issues one
// req/ack transaction at a time to instruction memory, buffers returned words
// with their address for decode, and produces the PC write enable.
// Ports:
//   CLK, RESET          : clock and synchronous active-high reset
//   pc_addr             : current instruction address from the PC
//   pc_wre              : PC write enable (combinational)
//   flush               : redirect pulse from execute
//   imem_req, imem_addr : registered memory request and address
//   imem_ack, imem_rdata: memory response; ack completes the request that cycle
//   dec_valid, dec_instr, dec_pc, dec_ready : decode handshake on buffer head
//   stall_cnt           : saturating count of memory wait cycles
// Build option:
//   FETCH_STALL_CNT_EN  : when defined, stall_cnt counts cycles with
//                         imem_req && !imem_ack; otherwise stall_cnt is 0.
// -----------------------------------------------------------------------------
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF,
  parameter int DEPTH   = 2
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [ADDR_W-1:0]  pc_addr,
  output logic               pc_wre,
  input  logic               flush,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               dec_valid,
  output logic [INSTR_W-1:0] dec_instr,
  output logic [ADDR_W-1:0]  dec_pc,
  input  logic               dec_ready,
  output logic [15:0]        stall_cnt
);

  localparam int CNT_W = fetch_cnt_w(DEPTH);

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } entry_t;

  fetch_state_e      state_q, state_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              push_s;
  logic              pop_s;
  logic              full_s;
  logic [CNT_W-1:0]  count_s;
  entry_t            push_data_s;
  entry_t            head_s;

  assign full_s    = (count_s == CNT_W'(DEPTH));
  assign dec_valid = (count_s != '0);
  // A pop coinciding with a flush is swallowed by the clear.
  assign pop_s     = dec_valid && dec_ready && !flush;

  // Fetch FSM next-state. Space is checked only at issue; since the count can
  // only fall while a request is outstanding, the eventual push always fits.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    push_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!flush && !full_s) begin
          state_d = ST_REQ;
          req_d   = 1'b1;
          addr_d  = pc_addr;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (imem_ack) begin
          push_s  = !flush;
          req_d   = 1'b0;
          state_d = ST_IDLE;
        end else if (flush) begin
          // Request cannot be withdrawn; wait for it and throw the data away.
          state_d = ST_DROP;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_DROP: begin
        if (imem_ack) begin
          req_d   = 1'b0;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DROP;
        end
      end
      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // FSM and request registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
    end
  end

  // PC advances on a completed kept fetch, or on a redirect (target chosen upstream).
  assign pc_wre = flush | push_s;

  assign imem_req  = req_q;
  assign imem_addr = addr_q;

  assign push_data_s.instr = imem_rdata;
  assign push_data_s.pc    = addr_q;

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk_i       (CLK),
    .rst_i       (RESET),
    .clear_i     (flush),
    .push_i      (push_s),
    .pop_i       (pop_s),
    .push_data_i (push_data_s),
    .head_o      (head_s),
    .count_o     (count_s)
  );

  assign dec_instr = head_s.instr;
  assign dec_pc    = head_s.pc;

`ifdef FETCH_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  // Saturating wait-cycle counter.
  always_comb begin
    if (req_q && !imem_ack && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end else begin
      stall_d = stall_q;
    end
  end

  // Stall counter register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      stall_q <= 16'd0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Self-checking bench for fetch_unit. A transaction-level model (outstanding
// flag, "discard" flag, queue of buffered {instr, pc}) predicts every output
// each cycle; directed scenarios are followed by a randomized run.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  localparam int AW    = 16;
  localparam int IW    = 32;
  localparam int DEPTH = 2;

  logic          CLK = 1'b0;
  logic          RESET = 1'b0;
  logic [AW-1:0] pc_addr = '0;
  logic          pc_wre;
  logic          flush = 1'b0;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack = 1'b0;
  logic [IW-1:0] imem_rdata = '0;
  logic          dec_valid;
  logic [IW-1:0] dec_instr;
  logic [AW-1:0] dec_pc;
  logic          dec_ready = 1'b0;
  logic [15:0]   stall_cnt;

  always #5 CLK = ~CLK;

  fetch_unit #(.ADDR_W(AW), .INSTR_W(IW), .DEPTH(DEPTH)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .pc_addr    (pc_addr),
    .pc_wre     (pc_wre),
    .flush      (flush),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .dec_valid  (dec_valid),
    .dec_instr  (dec_instr),
    .dec_pc     (dec_pc),
    .dec_ready  (dec_ready),
    .stall_cnt  (stall_cnt)
  );

  typedef struct {
    logic [IW-1:0] instr;
    logic [AW-1:0] pc;
  } ent_t;

  // Reference model state
  ent_t          q[$];
  bit            m_out;    // a request is outstanding
  bit            m_doom;   // outstanding request's data will be discarded
  bit            m_known;  // model synchronised by a reset
  bit            m_fresh;  // no push since reset: storage still all zero
  logic [AW-1:0] m_addr;
  int            m_stall;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_stall();
`ifdef FETCH_STALL_CNT_EN
    return 16'(m_stall);
`else
    return 16'd0;
`endif
  endfunction

  // One clock: drive inputs, check outputs against the model, advance the model.
  task automatic cycle(input bit rst, input bit ack, input bit fl, input bit rdy,
                       input logic [AW-1:0] pa, input logic [IW-1:0] rd);
    int sz;
    bit kept;
    @(negedge CLK);
    RESET = rst; imem_ack = ack; flush = fl; dec_ready = rdy;
    pc_addr = pa; imem_rdata = rd;
    #1;
    if (m_known) begin
      check("imem_req",  64'(imem_req),  64'(m_out));
      check("imem_addr", 64'(imem_addr), 64'(m_addr));
      check("dec_valid", 64'(dec_valid), 64'(q.size() != 0));
      if (q.size() != 0) begin
        check("dec_instr", 64'(dec_instr), 64'(q[0].instr));
        check("dec_pc",    64'(dec_pc),    64'(q[0].pc));
      end else if (m_fresh) begin
        check("dec_instr_rst", 64'(dec_instr), 64'd0);
        check("dec_pc_rst",    64'(dec_pc),    64'd0);
      end
      check("stall_cnt", 64'(stall_cnt), 64'(exp_stall()));
      if (!rst) begin
        kept = m_out && !m_doom && ack && !fl;
        check("pc_wre", 64'(pc_wre), 64'(fl | kept));
      end
    end
    // model update for this edge
    if (rst) begin
      q.delete();
      m_out = 1'b0; m_doom = 1'b0; m_addr = '0; m_stall = 0;
      m_known = 1'b1; m_fresh = 1'b1;
    end else begin
      sz = q.size();
      if (m_out && !ack && m_stall < 65535) m_stall++;
      if (fl) q.delete();
      else if (sz != 0 && rdy) void'(q.pop_front());
      if (m_out) begin
        if (ack) begin
          if (!m_doom && !fl) begin
            q.push_back('{rd, m_addr});
            m_fresh = 1'b0;
          end
          m_out = 1'b0; m_doom = 1'b0;
        end else if (fl) begin
          m_doom = 1'b1;
        end
      end else if (!fl && sz < DEPTH) begin
        m_out = 1'b1; m_addr = pa;
      end
    end
  endtask

  initial begin
    // Reset
    cycle(1, 0, 0, 0, 16'h0000, 32'h0);
    cycle(1, 1, 0, 0, 16'h0000, 32'h0);

    // S1: zero-wait fetch, latency
    cycle(0, 0, 0, 1, 16'h0000, 32'h0);          // IDLE -> issue
    check("s1_req", 64'(imem_req), 64'd0);
    cycle(0, 1, 0, 1, 16'h0004, 32'h11112222);   // req high, ack
    check("s1_pc_wre", 64'(pc_wre), 64'd1);
    check("s1_addr", 64'(imem_addr), 64'h0000);
    cycle(0, 0, 0, 1, 16'h0004, 32'h0);          // head visible
    check("s1_instr", 64'(dec_instr), 64'h11112222);
    check("s1_pc", 64'(dec_pc), 64'h0000);
    check("s1_pc_wre_once", 64'(pc_wre), 64'd0);

    // S2: back-pressure fills buffer, then drain in order
    cycle(1, 0, 0, 0, 16'h0000, 32'h0);
    for (int i = 0; i < 8; i++)
      cycle(0, m_out, 0, 0, 16'(16'h0100 + i * 4), 32'hB000_0000 + 32'(i));
    check("s2_full_noreq", 64'(imem_req), 64'd0);
    check("s2_full_pcwre", 64'(pc_wre), 64'd0);
    for (int i = 0; i < 6; i++)
      cycle(0, m_out, 0, 1, 16'(16'h0200 + i * 4), 32'hC000_0000 + 32'(i));

    // S3: five wait cycles, request held stable
    cycle(1, 0, 0, 0, 16'h0000, 32'h0);
    cycle(0, 0, 0, 1, 16'h0300, 32'h0);
    for (int i = 0; i < 5; i++)
      cycle(0, 0, 0, 1, 16'(16'h0310 + i), 32'h0);
    cycle(0, 1, 0, 1, 16'h0320, 32'hA5A5_0003);
`ifdef FETCH_STALL_CNT_EN
    check("s3_stall", 64'(stall_cnt), 64'd5);
`else
    check("s3_stall", 64'(stall_cnt), 64'd0);
`endif
    cycle(0, 0, 0, 1, 16'h0324, 32'h0);

    // S4: flush with ack low, ack two cycles later is discarded
    cycle(1, 0, 0, 0, 16'h0000, 32'h0);
    cycle(0, 0, 0, 1, 16'h0400, 32'h0);
    cycle(0, 0, 1, 1, 16'h0500, 32'h0);
    cycle(0, 0, 0, 1, 16'h0504, 32'h0);
    cycle(0, 1, 0, 1, 16'h0504, 32'hDEAD_BEEF);
    check("s4_drop_pcwre", 64'(pc_wre), 64'd0);
    cycle(0, 0, 0, 0, 16'h0504, 32'h0);
    check("s4_empty", 64'(dec_valid), 64'd0);

    // S5: one buffered entry, flush together with ack
    cycle(1, 0, 0, 0, 16'h0000, 32'h0);
    cycle(0, 0, 0, 0, 16'h0600, 32'h0);
    cycle(0, 1, 0, 0, 16'h0604, 32'h6000_0001);
    cycle(0, 0, 0, 0, 16'h0604, 32'h0);
    cycle(0, 1, 1, 0, 16'h0700, 32'h6000_0002);
    cycle(0, 0, 0, 0, 16'h0700, 32'h0);
    check("s5_empty", 64'(dec_valid), 64'd0);

    // S6: reset with a request outstanding and data buffered; late ack ignored
    cycle(1, 0, 0, 0, 16'h0000, 32'h0);
    for (int i = 0; i < 5; i++)
      cycle(0, m_out, 0, 0, 16'(16'h0800 + i * 4), 32'h8000_0000 + 32'(i));
    cycle(0, 0, 0, 1, 16'h0900, 32'h0);          // pop one
    cycle(0, 0, 0, 0, 16'h0900, 32'h0);          // issue
    cycle(1, 0, 0, 0, 16'h0900, 32'h0);          // reset mid-REQ
    cycle(0, 1, 0, 0, 16'h0A00, 32'hBAD0_0BAD);  // late ack in IDLE
    check("s6_req_after_rst", 64'(pc_wre), 64'd0);
    cycle(0, 0, 0, 0, 16'h0A00, 32'h0);

    // Randomized run
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 63) == 0, 1'($urandom_range(0, 1)),
            $urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)),
            16'($urandom), 32'($urandom));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
